// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch sequencer states (BOOT, RUN, FAULT)
//   NOP_INSTR     : encoding shown on the IF/ID bus when it holds nothing valid
//   PC_STEP       : byte increment between sequential fetches
//   if_id_t       : IF/ID payload, also consumed by decode
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with valid/ready output handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   kill                : drop the held entry (highest priority after reset)
//   load                : capture instr/pc/pc_plus4 and mark valid
//   ready               : downstream accepts the held entry this cycle
//   instr/pc/pc_plus4   : payload to capture
//   valid               : register holds a live instruction
//   q_instr/q_pc/q_pc4  : held payload; q_instr reads as NOP whenever !valid
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_plus4,
    output logic             valid,
    output logic [WIDTH-1:0] q_instr,
    output logic [WIDTH-1:0] q_pc,
    output logic [WIDTH-1:0] q_pc4
);

    logic [WIDTH-1:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            instr_q <= WIDTH'(NOP_INSTR);
            q_pc    <= '0;
            q_pc4   <= '0;
        end else if (kill) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            instr_q <= instr;
            q_pc    <= pc;
            q_pc4   <= pc_plus4;
        end else if (ready) begin
            // Entry consumed with nothing new behind it.
            valid <= 1'b0;
        end
    end

    // The NOP fill is applied on the output so an asynchronous reset or a
    // kill shows a NOP immediately, without rewriting the payload.
    assign q_instr = valid ? instr_q : WIDTH'(NOP_INSTR);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, addresses a
// combinational-read instruction memory and forwards each fetched word
// with its PC to decode through the IF/ID register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_addr_o       : word index sent to memory (pc_q[WIDTH-1:2])
//   imem_instr_i      : instruction for imem_addr_o, same cycle
//   redirect_valid_i  : redirect from execute; redirect_pc_i is the target
//   id_valid_o/id_ready_i : IF/ID handshake
//   id_instr_o, id_pc_o, id_pc_plus4_o : IF/ID payload
//   fault_o, fault_pc_o   : misaligned redirect fault and its target
//   dbg_state_o       : current sequencer state
//
// Handshake: an IF/ID entry transfers on a cycle where id_valid_o and
// id_ready_i are both high at the rising edge; while id_valid_o is high and
// id_ready_i low the entry and the PC stay frozen. A redirect in the same
// cycle kills the entry, so decode must ignore a coincident handshake.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-3:0] imem_addr_o,
    input  logic [WIDTH-1:0] imem_instr_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [WIDTH-1:0] id_instr_o,
    output logic [WIDTH-1:0] id_pc_o,
    output logic [WIDTH-1:0] id_pc_plus4_o,
    output logic             fault_o,
    output logic [WIDTH-1:0] fault_pc_o,
    output fetch_state_e     dbg_state_o
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_next_seq;
    logic             fault_d;
    logic [WIDTH-1:0] fault_pc_d;
    logic             fire;
    logic             misaligned;

    assign pc_next_seq = pc_q + WIDTH'(PC_STEP);
    assign misaligned  = |redirect_pc_i[1:0];
    assign imem_addr_o = pc_q[WIDTH-1:2];
    assign dbg_state_o = state_q;

    // Fetch only in RUN, never alongside a redirect, and only when the
    // IF/ID slot is empty or being drained this cycle.
    assign fire = (state_q == RUN) && !redirect_valid_i &&
                  (!id_valid_o || id_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            fault_o    <= 1'b0;
            fault_pc_o <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_o    <= fault_d;
            fault_pc_o <= fault_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_o;
        fault_pc_d = fault_pc_o;

        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
            if (misaligned) begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc_i;
            end else begin
                state_d = RUN;
                fault_d = 1'b0;
            end
        end else begin
            if (state_q == BOOT) begin
                state_d = RUN;
            end
            if (fire) begin
                pc_d = pc_next_seq;
            end
        end
    end

    if_id_reg #(
        .WIDTH(WIDTH)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .kill    (redirect_valid_i),
        .load    (fire),
        .ready   (id_ready_i),
        .instr   (imem_instr_i),
        .pc      (pc_q),
        .pc_plus4(pc_next_seq),
        .valid   (id_valid_o),
        .q_instr (id_instr_o),
        .q_pc    (id_pc_o),
        .q_pc4   (id_pc_plus4_o)
    );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned fetch address into the combinational-read instruction memory.
- Captures the returned instruction with its PC into an IF/ID register and hands it to decode over a valid/ready handshake.
- Handles branch/jump redirects, pipeline kill and misaligned-target faults.

Parameters:
WIDTH, 32, data/address width; the fetch address is WIDTH-2 bits (word index)
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr_o  output  WIDTH-2  word-aligned fetch address to instruction memory (PC[WIDTH-1:2])
imem_instr_i  input  WIDTH  instruction returned combinationally for imem_addr_o in the same cycle
redirect_valid_i  input  1  redirect request from execute (taken branch/jump/trap)
redirect_pc_i  input  WIDTH  redirect target byte address
id_valid_o  output  1  IF/ID register holds a valid instruction
id_ready_i  input  1  decode accepts the IF/ID contents this cycle
id_instr_o  output  WIDTH  fetched instruction (NOP 32'h00000013 when id_valid_o=0)
id_pc_o  output  WIDTH  byte PC of id_instr_o
id_pc_plus4_o  output  WIDTH  id_pc_o+4, modulo 2^WIDTH
fault_o  output  1  misaligned redirect fault latched
fault_pc_o  output  WIDTH  offending redirect target

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 forces state=BOOT, pc_q=RESET_PC, id_valid_o=0, id_instr_o=NOP, id_pc_o=0, id_pc_plus4_o=0, fault_o=0, fault_pc_o=0. Reset asserted mid-operation discards any held instruction immediately.
- imem_addr_o = pc_q[WIDTH-1:2] at all times; the low PC bits are never sent. Out-of-range PCs are not checked; the memory index wraps.
- States:
  - BOOT: lasts exactly one cycle after rst_n deasserts; no fetch; transitions to RUN.
  - RUN: normal fetching.
  - FAULT: no fetch, id_valid_o=0, fault_o=1.
- fire = (state==RUN) && !redirect_valid_i && (!id_valid_o || id_ready_i).
- On fire, at the next edge: id_instr_o<=imem_instr_i; id_pc_o<=pc_q; id_pc_plus4_o<=pc_q+4; id_valid_o<=1; pc_q<=pc_q+4. Addition wraps modulo 2^WIDTH.
- id_valid_o=1 && id_ready_i=0: the IF/ID register and pc_q hold unchanged, and no imem data is consumed.
- id_valid_o=1 && id_ready_i=1 && !fire (BOOT/FAULT): id_valid_o<=0.
- Throughput: one instruction per cycle with id_ready_i held high. Latency: the first valid instruction appears 2 cycles after rst_n rises (BOOT, then fetch at RESET_PC).
- Redirect has priority over everything except reset. When redirect_valid_i=1:
  - id_valid_o<=0 (kill the wrong-path instruction, even if decode is accepting it the same cycle; decode must ignore a handshake coincident with a redirect).
  - pc_q<=redirect_pc_i.
  - No fetch occurs that cycle.
  - If redirect_pc_i[1:0]!=0: state<=FAULT, fault_o<=1, fault_pc_o<=redirect_pc_i.
  - Else state<=RUN, fault_o<=0. This also exits FAULT.
- A redirect arriving during BOOT is honoured; state goes to RUN or FAULT as above.
- Back-to-back redirects: the last one wins; each kills the IF/ID register.
- In FAULT, only an aligned redirect or reset resumes fetching; fault_pc_o holds its value.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_e {BOOT, RUN, FAULT}
  - constant NOP_INSTR = 32'h00000013
  - constant PC_STEP = 4
  - typedef if_id_t {instr, pc, pc_plus4}, reused by decode
- One natural sub-module, if_id_reg: the valid/ready pipeline register with kill input, load enable and NOP fill. The PC/state logic stays in fetch_unit.

Test Plan:
- Reset release, RESET_PC=0, memory words 0..3 = A,B,C,D, id_ready_i=1 -> id_valid_o rises 2 cycles after rst_n; id_instr_o = A,B,C,D on consecutive cycles; id_pc_o = 0,4,8,12; id_pc_plus4_o = 4,8,12,16.
- Hold id_ready_i=0 for 3 cycles while holding B at PC 4 -> id_instr_o=B, id_pc_o=4 stable and imem_addr_o=2 throughout. Release -> C at PC 8 on the next edge, with no skip and no duplicate.
- Redirect to 0x40 while holding C, concurrent with id_ready_i=1 -> next cycle id_valid_o=0 and imem_addr_o=0x10; following cycle id_instr_o=mem[16], id_pc_o=0x40.
- Redirect to 0x42 -> fault_o=1, fault_pc_o=0x42, id_valid_o=0 for 5 idle cycles. Redirect to 0x80 -> fault_o=0 and fetch resumes at 0x80.
- rst_n pulsed low mid-stream while id_valid_o=1 -> id_valid_o=0 and id_instr_o=NOP immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC.
- PC=0xFFFF_FFFC fetch -> id_pc_plus4_o=0 and the next fetch is at PC 0.
